bsg_manycore_barrier_ctrl: RTL and testbench

Per-tile sequencer for the compute tile's barrier network node. It owns the barrier node's source-mask and destination-select configuration and runs sense-reversal join/complete handshakes for the core. It drives the node's P-port data bit and watches the returned P-port bit. It sits inside the compute tile between the core socket and the barrier node, and has an optional completion watchdog.

---
 rtl/bsg_manycore_barrier_ctrl.sv | 167 ++++++++++++++++
 tb/tb_bsg_manycore_barrier_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_barrier_ctrl.sv
// Per-tile barrier node sequencer: owns src-mask/dest-select config and runs sense-reversal joins.
// Optional completion watchdog enabled by defining BSG_MANYCORE_BARRIER_CTRL_TIMEOUT_EN.
module bsg_manycore_barrier_ctrl #(
    parameter int unsigned barrier_dirs_p   = 7,
    parameter int unsigned count_width_p    = 16,
    parameter int unsigned timeout_cycles_p = 4096,
    localparam int unsigned barrier_lg_dirs_lp =
        (barrier_dirs_p + 1 > 1) ? $clog2(barrier_dirs_p + 1) : 1
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          cfg_v_i,
    input  logic [barrier_dirs_p-1:0]     cfg_src_i,
    input  logic [barrier_lg_dirs_lp-1:0] cfg_dest_i,
    output logic                          cfg_ready_o,
    output logic                          cfg_err_o,
    input  logic                          join_v_i,
    output logic                          join_ready_o,
    output logic                          done_o,
    output logic                          busy_o,
    output logic                          barrier_data_o,
    input  logic                          barrier_data_i,
    output logic [barrier_dirs_p-1:0]     barrier_src_r_o,
    output logic [barrier_lg_dirs_lp-1:0] barrier_dest_r_o,
    output logic [count_width_p-1:0]      barrier_count_o,
    output logic                          timeout_o
);

    if (timeout_cycles_p < 2) begin : g_bad_timeout_cfg
        $error("timeout_cycles_p must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1
`ifdef BSG_MANYCORE_BARRIER_CTRL_TIMEOUT_EN
        , TIMEOUT = 2'd2
`endif
    } state_e;

    // Lookup of legal destination selects; avoids a range compare that folds to constant.
    localparam int unsigned dest_slots_lp = 1 << barrier_lg_dirs_lp;

    function automatic logic [dest_slots_lp-1:0] dest_ok_mask();
        logic [dest_slots_lp-1:0] m;
        for (int unsigned i = 0; i < dest_slots_lp; i++) m[i] = (i <= barrier_dirs_p);
        return m;
    endfunction

    localparam logic [dest_slots_lp-1:0] dest_ok_lp = dest_ok_mask();

    state_e                          state_q, state_d;
    logic                            sense_q, sense_d;
    logic [barrier_dirs_p-1:0]       src_q, src_d;
    logic [barrier_lg_dirs_lp-1:0]   dest_q, dest_d;
    logic [count_width_p-1:0]        count_q, count_d;
    logic                            done_q, done_d;
    logic                            err_q, err_d;
    logic                            match;

`ifdef BSG_MANYCORE_BARRIER_CTRL_TIMEOUT_EN
    localparam int unsigned         tmr_w_lp    = $clog2(timeout_cycles_p);
    localparam logic [tmr_w_lp-1:0] tmr_last_lp = tmr_w_lp'(timeout_cycles_p - 1);
    logic [tmr_w_lp-1:0]            tmr_q, tmr_d;
`endif

    assign match = (barrier_data_i == sense_q);

    always_comb begin
        state_d = state_q;
        sense_d = sense_q;
        src_d   = src_q;
        dest_d  = dest_q;
        count_d = count_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef BSG_MANYCORE_BARRIER_CTRL_TIMEOUT_EN
        tmr_d   = tmr_q;
`endif
        case (state_q)
            IDLE: begin
                if (cfg_v_i) begin
                    if (dest_ok_lp[cfg_dest_i]) begin
                        src_d  = cfg_src_i;
                        dest_d = cfg_dest_i;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (join_v_i && join_ready_o) begin
                    sense_d = ~sense_q;
                    state_d = WAIT;
`ifdef BSG_MANYCORE_BARRIER_CTRL_TIMEOUT_EN
                    tmr_d   = '0;
`endif
                end
            end
            WAIT: begin
                if (match) begin
                    done_d  = 1'b1;
                    count_d = count_q + count_width_p'(1);
                    state_d = IDLE;
                end
`ifdef BSG_MANYCORE_BARRIER_CTRL_TIMEOUT_EN
                else if (tmr_q == tmr_last_lp) begin
                    state_d = TIMEOUT;
                end else begin
                    tmr_d = tmr_q + tmr_w_lp'(1);
                end
`endif
            end
`ifdef BSG_MANYCORE_BARRIER_CTRL_TIMEOUT_EN
            TIMEOUT: begin
                if (match) begin
                    done_d  = 1'b1;
                    count_d = count_q + count_width_p'(1);
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            sense_q <= 1'b0;
            src_q   <= '0;
            dest_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef BSG_MANYCORE_BARRIER_CTRL_TIMEOUT_EN
            tmr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sense_q <= sense_d;
            src_q   <= src_d;
            dest_q  <= dest_d;
            count_q <= count_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef BSG_MANYCORE_BARRIER_CTRL_TIMEOUT_EN
            tmr_q   <= tmr_d;
`endif
        end
    end

    // The done pulse lands in IDLE, so joins are held off for that one cycle to keep them disjoint.
    assign cfg_ready_o      = (state_q == IDLE);
    assign join_ready_o     = (state_q == IDLE) && !done_q;
    assign busy_o           = (state_q != IDLE);
    assign done_o           = done_q;
    assign cfg_err_o        = err_q;
    assign barrier_data_o   = sense_q;
    assign barrier_src_r_o  = src_q;
    assign barrier_dest_r_o = dest_q;
    assign barrier_count_o  = count_q;
`ifdef BSG_MANYCORE_BARRIER_CTRL_TIMEOUT_EN
    assign timeout_o        = (state_q == TIMEOUT);
`else
    assign timeout_o        = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_manycore_barrier_ctrl.sv
// Scoreboard bench for bsg_manycore_barrier_ctrl: directed stimulus queues expected pulses,
// a negedge monitor pops and compares whenever done/cfg_err fire.
`timescale 1ns/1ps
module tb_bsg_manycore_barrier_ctrl;
    localparam int unsigned DIRS = 7;
    localparam int unsigned LG   = 3;
    localparam int unsigned CW   = 16;
    localparam int unsigned TMO  = 8;
`ifdef BSG_MANYCORE_BARRIER_CTRL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cfg_v, join_v, loopback, man_data;
    logic [DIRS-1:0] cfg_src;
    logic [LG-1:0]   cfg_dest;
    logic            cfg_ready, cfg_err, join_ready, done, busy, bdo, bdi, timeout;
    logic [DIRS-1:0] src_r;
    logic [LG-1:0]   dest_r;
    logic [CW-1:0]   count;

    // Second instance with 5 ports: destination selects 6 and 7 are illegal there.
    logic       e_cfg_v;
    logic [4:0] e_cfg_src;
    logic [2:0] e_cfg_dest;
    logic       e_cfg_ready, e_cfg_err, e_join_ready, e_done, e_busy, e_bdo, e_timeout;
    logic [4:0] e_src_r;
    logic [2:0] e_dest_r;
    logic [3:0] e_count;
    logic       zero = 1'b0;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    assign bdi = loopback ? bdo : man_data;

    bsg_manycore_barrier_ctrl #(
        .barrier_dirs_p(DIRS), .count_width_p(CW), .timeout_cycles_p(TMO)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .cfg_v_i(cfg_v), .cfg_src_i(cfg_src), .cfg_dest_i(cfg_dest),
        .cfg_ready_o(cfg_ready), .cfg_err_o(cfg_err),
        .join_v_i(join_v), .join_ready_o(join_ready),
        .done_o(done), .busy_o(busy),
        .barrier_data_o(bdo), .barrier_data_i(bdi),
        .barrier_src_r_o(src_r), .barrier_dest_r_o(dest_r),
        .barrier_count_o(count), .timeout_o(timeout)
    );

    bsg_manycore_barrier_ctrl #(
        .barrier_dirs_p(5), .count_width_p(4), .timeout_cycles_p(TMO)
    ) u_err (
        .clk_i(clk), .reset_n_i(rst_n),
        .cfg_v_i(e_cfg_v), .cfg_src_i(e_cfg_src), .cfg_dest_i(e_cfg_dest),
        .cfg_ready_o(e_cfg_ready), .cfg_err_o(e_cfg_err),
        .join_v_i(zero), .join_ready_o(e_join_ready),
        .done_o(e_done), .busy_o(e_busy),
        .barrier_data_o(e_bdo), .barrier_data_i(zero),
        .barrier_src_r_o(e_src_r), .barrier_dest_r_o(e_dest_r),
        .barrier_count_o(e_count), .timeout_o(e_timeout)
    );

    typedef struct {
        int unsigned   kind;  // 0 main done, 1 main cfg_err, 2 u_err cfg_err
        int unsigned   cyc;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_pulse(input int unsigned kind, input int unsigned at,
                                input logic [CW-1:0] cnt);
        exp_t e;
        e.kind = kind;
        e.cyc  = at;
        e.cnt  = cnt;
        sb.push_back(e);
    endtask

    task automatic take_pulse(input int unsigned kind, input logic [CW-1:0] cnt);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected pulse: got kind %0d, expected none (cycle %0d)", kind, cyc);
        end else begin
            e = sb.pop_front();
            chk("pulse kind", kind, e.kind);
            chk("pulse cycle", cyc, e.cyc);
            if (kind == 0) chk("done count", cnt, e.cnt);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                take_pulse(0, count);
                chk("done vs join_ready", join_ready, 0);
            end
            if (cfg_err)   take_pulse(1, '0);
            if (e_cfg_err) take_pulse(2, '0);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_join(output int unsigned jc);
        join_v = 1'b1;
        jc     = cyc + 1;
        @(negedge clk);
        join_v = 1'b0;
    endtask

    logic [CW-1:0] exp_cnt;
    int unsigned   j;
    logic          exp_to;

    initial begin
        #100us;
        $display("FAIL global time limit: got no finish, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0; cfg_v = 1'b0; join_v = 1'b0; cfg_src = '0; cfg_dest = '0;
        loopback = 1'b0; man_data = 1'b0;
        e_cfg_v = 1'b0; e_cfg_src = '0; e_cfg_dest = '0;
        exp_cnt = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        chk("reset zeros", {bdo, src_r, dest_r, count, done, cfg_err, timeout, busy}, '0);
        chk("reset ready", {cfg_ready, join_ready}, 2'b11);
        chk("u_err reset", {e_src_r, e_dest_r, e_busy, e_cfg_ready}, 32'h1);

        // Basic config and two loopback barriers
        cfg_v = 1'b1; cfg_src = 7'b0000001; cfg_dest = 3'd0;
        tick();
        cfg_v = 1'b0;
        chk("cfg src", src_r, 7'h01);
        chk("cfg dest", dest_r, 0);
        loopback = 1'b1;
        for (int n = 0; n < 2; n++) begin
            exp_cnt = exp_cnt + 1'b1;
            expect_pulse(0, cyc + 2, exp_cnt);
            start_join(j);
            chk("data_o after join", bdo, (n == 0) ? 1 : 0);
            chk("busy in wait", busy, 1);
            chk("join_ready in wait", join_ready, 0);
            tick();
            tick();
            chk("count after done", count, exp_cnt);
            chk("idle after done", busy, 0);
        end

        // Highest legal dest accepted; illegal dest rejected on the 5-port instance
        cfg_v = 1'b1; cfg_src = 7'h55; cfg_dest = 3'd7;
        tick();
        cfg_v = 1'b0;
        chk("cfg src max dest", src_r, 7'h55);
        chk("cfg dest max", dest_r, 7);
        e_cfg_v = 1'b1; e_cfg_src = 5'h0A; e_cfg_dest = 3'd5;
        tick();
        e_cfg_v = 1'b0;
        chk("u_err src ok", e_src_r, 5'h0A);
        chk("u_err dest ok", e_dest_r, 5);
        for (int d = 6; d < 8; d++) begin
            e_cfg_v = 1'b1; e_cfg_src = 5'h1F; e_cfg_dest = 3'(d);
            expect_pulse(2, cyc + 1, '0);
            tick();
            e_cfg_v = 1'b0;
            chk("u_err src kept", e_src_r, 5'h0A);
            chk("u_err dest kept", e_dest_r, 5);
        end
        tick();

        // Long wait with cfg attempt during WAIT
        loopback = 1'b0; man_data = 1'b0;
        start_join(j);
        cfg_v = 1'b1; cfg_src = 7'h7F; cfg_dest = 3'd2;
        chk("cfg_ready in wait", cfg_ready, 0);
        tick();
        cfg_v = 1'b0;
        chk("src kept in wait", src_r, 7'h55);
        chk("dest kept in wait", dest_r, 7);
        while (cyc < j + 49) begin
            chk("busy long wait", busy, 1);
            chk("join_ready long wait", join_ready, 0);
            tick();
        end
        man_data = 1'b1;
        exp_cnt  = exp_cnt + 1'b1;
        expect_pulse(0, j + 50, exp_cnt);
        tick();
        tick();
        chk("count long wait", count, exp_cnt);
        chk("idle long wait", busy, 0);

        // Simultaneous cfg + join
        loopback = 1'b1;
        cfg_v = 1'b1; cfg_src = 7'h12; cfg_dest = 3'd3;
        exp_cnt = exp_cnt + 1'b1;
        expect_pulse(0, cyc + 2, exp_cnt);
        start_join(j);
        cfg_v = 1'b0;
        chk("simul src", src_r, 7'h12);
        chk("simul dest", dest_r, 3);
        chk("simul data_o", bdo, 0);
        tick();
        tick();
        chk("simul count", count, exp_cnt);

        // Watchdog window; data_i rises in cycle 20 after the join edge
        loopback = 1'b0; man_data = 1'b0;
        exp_cnt = exp_cnt + 1'b1;
        expect_pulse(0, cyc + 21, exp_cnt);
        start_join(j);
        while (cyc < j + 20) begin
            exp_to = TMO_EN && (cyc >= j + 8) && (cyc <= j + 19);
            chk("timeout level", timeout, exp_to);
            chk("busy watchdog", busy, 1);
            if (cyc == j + 19) man_data = 1'b1;
            tick();
        end
        chk("timeout cleared", timeout, 0);
        tick();
        chk("count watchdog", count, exp_cnt);

        // Asynchronous reset mid-WAIT
        start_join(j);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("abort clears", {bdo, src_r, dest_r, count, done, busy, timeout}, '0);
        chk("abort ready", {cfg_ready, join_ready}, 2'b11);
        tick();
        tick();
        rst_n   = 1'b1;
        exp_cnt = '0;
        tick();
        tick();
        chk("idle after abort", busy, 0);

        // Counter wrap
        force dut.count_q = 16'hFFFF;
        tick();
        release dut.count_q;
        chk("count preset", count, 16'hFFFF);
        loopback = 1'b1;
        expect_pulse(0, cyc + 2, 16'h0000);
        start_join(j);
        chk("data_o after reset join", bdo, 1);
        tick();
        tick();
        chk("count wrapped", count, 0);

        repeat (3) tick();
        chk("scoreboard drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
